// File: rtl/parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parity_pkg
// Description : Shared state encoding and frame constants for parity_frame_tx.
// Revision    : 1.0 - initial release
// ============================================================================
package parity_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Flat encodings so the state register can stay a plain logic vector.
   localparam logic [2:0] ST_IDLE   = IDLE;
   localparam logic [2:0] ST_START  = START;
   localparam logic [2:0] ST_DATA   = DATA;
   localparam logic [2:0] ST_PARITY = PARITY;
   localparam logic [2:0] ST_STOP   = STOP;

   localparam int FRAME_BITS = 19;
   localparam int DATA_W     = 16;

endpackage : parity_pkg
`default_nettype wire

// File: rtl/parity16_gen.sv
`default_nettype none
// ============================================================================
// Module      : parity16_gen
// Description : Combinational XOR reduction of a 16-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module parity16_gen (
   input  logic [15:0] data,
   output logic        parity
);

   assign parity = ^data;

endmodule : parity16_gen
`default_nettype wire

// File: rtl/parity_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_tx
// Description : Accepts a 16-bit word and serialises start, data LSB first,
//               parity and stop bits onto a single idle-high line.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_tx #(
   parameter int DATA_W       = parity_pkg::DATA_W,
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              parity_out,
   output logic              done
);
   import parity_pkg::*;

   localparam int                 c_cnt_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(CLKS_PER_BIT - 1);
   localparam logic [3:0]         c_last_idx = 4'(DATA_W - 1);

   logic [2:0]         r_state,   w_state_nxt;
   logic [c_cnt_w-1:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [3:0]         r_bit_idx, w_bit_idx_nxt;
   logic [DATA_W-1:0]  r_shift,   w_shift_nxt;
   logic               r_parity,  w_parity_nxt;
   logic               r_tx,      w_tx_nxt;
   logic               r_done,    w_done_nxt;
   logic               w_accept;
   logic               w_bit_end;
   logic               w_word_parity;

   parity16_gen u_parity_gen (
      .data   (in_data),
      .parity (w_word_parity)
   );

   assign in_ready   = (r_state == ST_IDLE);
   assign busy       = (r_state != ST_IDLE);
   assign tx_out     = r_tx;
   assign parity_out = r_parity;
   assign done       = r_done;

   assign w_accept  = in_valid && in_ready;
   assign w_bit_end = (r_bit_cnt == c_last_cnt);

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_parity_nxt  = r_parity;

      if (r_state != ST_IDLE) begin
         w_bit_cnt_nxt = w_bit_end ? '0 : r_bit_cnt + 1'b1;
      end

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt   = ST_START;
               w_bit_cnt_nxt = '0;
               w_bit_idx_nxt = '0;
               w_shift_nxt   = in_data;
               w_parity_nxt  = w_word_parity ^ PARITY_ODD;
            end
         end
         ST_START: begin
            if (w_bit_end) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_bit_end) begin
               w_shift_nxt = r_shift >> 1;
               if (r_bit_idx == c_last_idx) begin
                  w_state_nxt   = ST_PARITY;
                  w_bit_idx_nxt = '0;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_end) w_state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (w_bit_end) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Line level is registered, so it is decoded from the next-state view.
      case (w_state_nxt)
         ST_START:  w_tx_nxt = 1'b0;
         ST_DATA:   w_tx_nxt = w_shift_nxt[0];
         ST_PARITY: w_tx_nxt = w_parity_nxt;
         default:   w_tx_nxt = 1'b1;
      endcase

      w_done_nxt = (w_state_nxt == ST_STOP) && (w_bit_cnt_nxt == c_last_cnt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_parity  <= w_parity_nxt;
         r_tx      <= w_tx_nxt;
         r_done    <= w_done_nxt;
      end
   end

endmodule : parity_frame_tx
`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_tx
// Description : Scoreboard bench for parity_frame_tx with directed words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 19 * CPB;

   typedef struct {
      logic [15:0] data;
      logic        par;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, tx_out, busy, parity_out, done;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   frames_started = 0;
   int   frames_done = 0;
   int   frames_aborted = 0;

   parity_frame_tx #(
      .DATA_W       (16),
      .CLKS_PER_BIT (CPB),
      .PARITY_ODD   (1'b0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_out     (tx_out),
      .busy       (busy),
      .parity_out (parity_out),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Present a word at a falling edge and record its expectation before the accept edge.
   task automatic send(input logic [15:0] d, input logic par, input bit hold);
      int k;
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 500) begin
         @(negedge clk);
         k++;
      end
      check("accept_ready", in_ready, 1);
      exp_q.push_back('{data: d, par: par});
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      int k;
      k = 0;
      while (frames_done < target && k < 1000) begin
         @(negedge clk);
         k++;
      end
      check("frame_complete", frames_done, target);
   endtask

   // Monitor: a frame begins at the first falling edge where busy is seen.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && busy) begin
            exp_t        e;
            logic [18:0] got;
            logic [18:0] want;
            int          done_bad;
            int          busy_bad;
            bit          aborted;
            e = '{data: 16'h0, par: 1'b0};
            check("frame_expected", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            frames_started++;
            want     = {1'b1, e.par, e.data, 1'b0};
            got      = '0;
            done_bad = 0;
            busy_bad = 0;
            aborted  = 1'b0;
            for (int c = 1; c <= FRAME; c++) begin
               if (c > 1) @(negedge clk);
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (!busy || in_ready) busy_bad++;
               if (done !== (c == FRAME)) done_bad++;
               if ((c - 1) % CPB == CPB / 2) got[(c - 1) / CPB] = tx_out;
               if (c == 1) check("parity_out", parity_out, e.par);
            end
            if (aborted) begin
               frames_aborted++;
            end else begin
               check("serial_bits", got, want);
               check("done_timing", done_bad, 0);
               check("busy_window", busy_bad, 0);
               @(negedge clk);
               check("idle_after", {busy, in_ready, tx_out, done}, 4'b0110);
               frames_done++;
            end
         end
      end
   end

   initial begin
      int n;

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_data  = 16'($urandom);
         in_valid = 1'($urandom);
      end
      check("rst_tx",     tx_out,     1);
      check("rst_ready",  in_ready,   1);
      check("rst_busy",   busy,       0);
      check("rst_done",   done,       0);
      check("rst_parity", parity_out, 0);
      in_valid = 1'b0;
      rst_n    = 1'b1;

      send(16'h0000, 1'b0, 1'b0); wait_frames(1);
      send(16'h0001, 1'b1, 1'b0); wait_frames(2);
      send(16'hA5C3, 1'b0, 1'b0); wait_frames(3);
      send(16'h8000, 1'b1, 1'b0); wait_frames(4);

      // Back-to-back with in_valid held; in_data swapped mid-frame
      send(16'h0007, 1'b1, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 3) in_data = 16'hFFFF;
      end while (!in_ready && n < 200);
      check("b2b_gap", n, FRAME + 1);
      exp_q.push_back('{data: 16'hFFFF, par: 1'b0});
      @(posedge clk);
      #1 in_valid = 1'b0;
      wait_frames(6);

      // Reset during DATA bit 5
      send(16'h00FF, 1'b0, 1'b0);
      repeat (27) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tx",     tx_out,     1);
      check("midrst_busy",   busy,       0);
      check("midrst_ready",  in_ready,   1);
      check("midrst_parity", parity_out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("midrst_abort", frames_aborted, 1);

      // Clean frame after reset, with an in_valid pulse during PARITY
      send(16'h0003, 1'b0, 1'b0);
      repeat (70) @(negedge clk);
      in_data  = 16'h1234;
      in_valid = 1'b1;
      check("ignore_ready", in_ready, 0);
      @(negedge clk);
      in_valid = 1'b0;
      check("ignore_parity", parity_out, 0);
      wait_frames(7);
      repeat (30) @(negedge clk);
      check("no_extra_frame", frames_started, 8);
      check("queue_empty", exp_q.size(), 0);
      check("final_idle", {busy, tx_out}, 2'b01);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_parity_frame_tx
`default_nettype wire
